// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the mem_ctrl CPU-to-RAM bridge:
// FSM state encoding, default widths and the MMIO register addresses.
package mem_ctrl_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 8;

   // Full CPU addresses; the top bit selects I/O space.
   localparam logic [8:0] LED_ADDR = 9'h100;
   localparam logic [8:0] SW_ADDR  = 9'h140;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_ADDR = 2'd1,
      RD_DATA = 2'd2,
      WR      = 2'd3
   } state_t;

endpackage

// File: rtl/mem_ctrl_mmio.sv
// I/O-space decode for mem_ctrl: LED output register and switch readback.
// Instantiated by mem_ctrl only when MEM_CTRL_MMIO_EN is defined.
module mem_ctrl_mmio
   import mem_ctrl_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic              rd_sel,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        sw,
   output logic [7:0]        led,
   output logic [DATA_W-1:0] rd_data
);

   // Offsets inside I/O space (the I/O select bit is already stripped).
   localparam logic [ADDR_W-1:0] LED_OFF = ADDR_W'(LED_ADDR);
   localparam logic [ADDR_W-1:0] SW_OFF  = ADDR_W'(SW_ADDR);

   // LED register, written on the accept edge of an I/O store.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         led <= 8'h00;
      end else if (wr_en && (wr_addr == LED_OFF)) begin
         led <= wr_data;
      end else begin
         led <= led;
      end
   end

   // Switch readback; every other I/O location reads as zero.
   always_comb begin
      rd_data = {DATA_W{1'b0}};
      if (rd_sel && (rd_addr == SW_OFF)) begin
         rd_data = DATA_W'(sw);
      end else begin
         rd_data = {DATA_W{1'b0}};
      end
   end

endmodule

// File: rtl/mem_ctrl.sv
// Single-outstanding CPU-to-synchronous-RAM controller (2-cycle load, 1-cycle store).
// Optional I/O decode (LED/switches) is compiled in with MEM_CTRL_MMIO_EN.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W:0]   req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] ram_read_address,
   output logic [ADDR_W-1:0] ram_write_address,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   input  logic [7:0]        sw,
   output logic [7:0]        led
);

   state_t            state;
   state_t            state_nxt;
   logic              accept;
   logic              req_io;
   logic              rd_io;
   logic [DATA_W-1:0] io_rdata;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid & req_ready;

`ifdef MEM_CTRL_MMIO_EN
   assign req_io = req_addr[ADDR_W];

   mem_ctrl_mmio #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mmio (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (accept & req_write & req_io),
      .wr_addr (req_addr[ADDR_W-1:0]),
      .wr_data (req_wdata[7:0]),
      .rd_sel  (rd_io),
      .rd_addr (ram_read_address),
      .sw      (sw),
      .led     (led),
      .rd_data (io_rdata)
   );
`else
   // I/O space aliases RAM; switches are not observed.
   logic unused_io;
   assign unused_io = ^{sw, req_addr[ADDR_W]};
   assign req_io    = 1'b0;
   assign io_rdata  = {DATA_W{1'b0}};
   assign led       = 8'h00;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; I/O stores still pass through WR so latency matches RAM.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = req_write ? WR : RD_ADDR;
            end else begin
               state_nxt = IDLE;
            end
         end
         RD_ADDR: state_nxt = RD_DATA;
         RD_DATA: state_nxt = IDLE;
         WR:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath registers: address/data capture on accept, response on RD_DATA exit.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rsp_valid         <= 1'b0;
         rsp_rdata         <= {DATA_W{1'b0}};
         ram_read_address  <= {ADDR_W{1'b0}};
         ram_write_address <= {ADDR_W{1'b0}};
         ram_write         <= 1'b0;
         ram_din           <= {DATA_W{1'b0}};
         rd_io             <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         ram_write <= 1'b0;
         if (accept && req_write && !req_io) begin
            ram_write_address <= req_addr[ADDR_W-1:0];
            ram_din           <= req_wdata;
            ram_write         <= 1'b1;
         end else if (accept && !req_write) begin
            ram_read_address <= req_addr[ADDR_W-1:0];
            rd_io            <= req_io;
         end
         if (state == RD_DATA) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rd_io ? io_rdata : ram_dout;
         end
      end
   end

endmodule
